// File: rtl/updn_ctr_mod.sv
// Up/down counter over programmable bounds lo..hi with wrap, saturate and bounce modes.
// Define UPDN_CTR_CAPTURE_EN to enable the cap_q count snapshot register.
module updn_ctr_mod #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             cen,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             clr_ovf,
  input  logic             capture,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tercnt,
  output logic             carry_o,
  output logic             wrap_p,
  output logic             ovf,
  output logic [WIDTH-1:0] cap_q
);

  localparam logic [1:0] M_SAT = 2'b01;
  localparam logic [1:0] M_BNC = 2'b10;

  logic             dir_q;
  logic             bounce;
  logic             illegal;
  logic             in_range;
  logic             at_hi;
  logic             at_lo;
  logic             at_bnd;
  logic             do_step;
  logic             do_hold;
  logic [WIDTH-1:0] cnt_d;
  logic             dirq_d;
  logic             wp_d;
  logic             ovf_set;
  logic             ovf_d;

  assign bounce   = (mode == M_BNC);
  assign dir      = bounce ? dir_q : up_dn;
  assign illegal  = (lo > hi);
  assign in_range = (count >= lo) && (count <= hi);
  assign at_hi    = (count == hi);
  assign at_lo    = (count == lo);
  assign at_bnd   = dir ? at_hi : at_lo;
  assign tercnt   = ~illegal & ((dir & at_hi) | (~dir & at_lo));
  assign carry_o  = cen & tercnt & ~load;
  assign do_step  = ~load & cen;
  assign do_hold  = ~load & ~cen;

  always_comb begin
    cnt_d   = count;
    dirq_d  = bounce ? dir_q : up_dn;
    wp_d    = 1'b0;
    ovf_set = 1'b0;
    unique case (1'b1)
      load: begin
        cnt_d  = data;
        dirq_d = up_dn;
      end
      do_step: begin
        if (illegal) begin
          cnt_d = count;
        end else if (!in_range) begin
          // recover into range from the side we are heading towards
          cnt_d = dir ? lo : hi;
          wp_d  = 1'b1;
        end else if (!at_bnd) begin
          cnt_d = dir ? count + WIDTH'(1) : count - WIDTH'(1);
        end else if (bounce) begin
          dirq_d = ~dir_q;
          wp_d   = 1'b1;
          if (lo != hi)
            cnt_d = dir ? count - WIDTH'(1) : count + WIDTH'(1);
        end else if (mode == M_SAT) begin
          ovf_set = 1'b1;
        end else begin
          cnt_d   = dir ? lo : hi;
          wp_d    = 1'b1;
          ovf_set = 1'b1;
        end
      end
      do_hold: begin
        cnt_d = count;
      end
      default: begin
        cnt_d = count;
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf;
    if (load)
      ovf_d = 1'b0;
    else if (ovf_set)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      dir_q  <= 1'b1;
      wrap_p <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      count  <= cnt_d;
      dir_q  <= dirq_d;
      wrap_p <= wp_d;
      ovf    <= ovf_d;
    end
  end

`ifdef UPDN_CTR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!reset)
      cap_q <= '0;
    else if (capture)
      cap_q <= count;
  end
`else
  assign cap_q = {WIDTH{capture & 1'b0}};
`endif

endmodule

// File: doc/updn_ctr_mod.md
Name: updn_ctr_mod

Overview:
Parametrised up/down counter that counts between programmable bounds lo..hi. Supports load, count enable and three boundary modes: wrap, saturate and bounce (ping-pong). Provides a terminal-count flag, a carry-out for cascading, a wrap pulse and a sticky overflow flag. Used as a general timing and sequencing counter in the datapath and replaces fixed-width, fixed-terminal counters.

Parameters:
WIDTH, 8, counter, data and bound width in bits; unsigned arithmetic, WIDTH >= 2.

Ports:
clk      in   1      rising-edge clock
reset    in   1      synchronous, active-low reset
load     in   1      active-high; count <= data on the next edge
data     in   WIDTH  load value
cen      in   1      active-high count enable
up_dn    in   1      1 = up, 0 = down; in bounce mode sampled only on load
mode     in   2      00 wrap, 01 saturate, 10 bounce, 11 treated as wrap
lo       in   WIDTH  lower bound (inclusive)
hi       in   WIDTH  upper bound (inclusive)
clr_ovf  in   1      clears ovf
capture  in   1      snapshot strobe (optional feature)
count    out  WIDTH  registered count
dir      out  1      effective direction (1 = up)
tercnt   out  1      combinational: count at the bound in the effective direction
carry_o  out  1      combinational: cen & tercnt & ~load, for cascading
wrap_p   out  1      registered one-cycle pulse on wrap, bounce reversal or range recovery
ovf      out  1      sticky: set on wrap or saturate-hit
cap_q    out  WIDTH  captured count (optional feature)

Behaviour:
- All state updates occur on the clk rising edge. Priority: reset=0 > load > cen step > hold.
- Reset (reset=0): count=0, dir_q=1, wrap_p=0, ovf=0, cap_q=0.
- Effective dir: modes 00, 01 and 11 use dir=up_dn. Mode 10 uses dir=dir_q.
- dir_q tracking:
  - dir_q <= up_dn every cycle while mode != 10, so entering bounce continues in the last commanded direction.
  - In mode 10, dir_q changes only on load (dir_q <= up_dn) or on a reversal.
- Load: count <= data, even if data is out of range. wrap_p <= 0. ovf <= 0, and load clears ovf regardless of clr_ovf.
- cen=0 with no load: count holds, wrap_p <= 0.
- Enabled step (cen=1, load=0), evaluated in this order:
  - lo > hi (illegal bounds): count holds, no flag changes, wrap_p <= 0.
  - count outside [lo,hi]: count <= lo if dir=1, else hi. wrap_p <= 1; ovf unchanged.
  - Not at the bound in dir: count <= count+1 if up, count-1 if down. wrap_p <= 0.
  - At the bound in wrap mode: count <= lo (up) or hi (down). wrap_p <= 1, ovf <= 1.
  - At the bound in saturate mode: count holds. wrap_p <= 0, ovf <= 1. Setting recurs on every enabled cycle at the bound.
  - At the bound in bounce mode: dir_q toggles. Count moves one step in the new direction (hi-1 or lo+1). If lo==hi, count holds. wrap_p <= 1; ovf unchanged.
- tercnt = (dir & count==hi) | (~dir & count==lo). It is independent of cen and 0 when lo > hi.
- ovf update: clr_ovf=1 clears ovf. If a set event occurs in the same cycle, the set wins.
- Bounds or mode changed mid-count take effect on the next edge. No internal latching of lo, hi or mode.
- Arithmetic is unsigned modulo 2^WIDTH. With lo=0 and hi=2^WIDTH-1, wrap mode behaves as a free-running counter.

Optional Feature:
Macro UPDN_CTR_CAPTURE_EN.
- Defined: on capture=1 (reset=1), cap_q <= the current count value (pre-update) on that edge. Otherwise cap_q holds. Reset clears cap_q.
- Undefined: capture is ignored and cap_q is tied to 0. The port list is unchanged in both builds.

Test Plan:
- WIDTH=4, reset=0 for 2 cycles with load=1, cen=1 -> count=0, dir=1, ovf=0, wrap_p=0. Release reset with load=0 -> count increments from 0 on the next edge.
- mode=00, lo=3, hi=9, up, cen=1 from count=3 -> count 3..9, then 3. tercnt=1 while count=9. carry_o=1 on that cycle. wrap_p=1 the cycle count=3 appears. ovf=1 stays set until clr_ovf=1.
- mode=01, lo=2, hi=5, down from load data=4 -> count 4,3,2,2,2. ovf sets on the first hold at 2. clr_ovf=1 on a cycle at the bound -> ovf stays 1 (set wins).
- mode=10, lo=1, hi=4, load data=1 with up_dn=1, then up_dn toggled randomly -> count 1,2,3,4,3,2,1,2. dir falls at 4 and rises at 1. wrap_p pulses at each reversal. ovf stays 0.
- mode=00, lo=2, hi=6, load data=12 then cen=1 up -> count=2, wrap_p=1. Then set lo=7, hi=3 -> count holds and tercnt=0.
- UPDN_CTR_CAPTURE_EN defined, count stepping 5->6 with capture=1 on that edge -> cap_q=5. Build without the macro -> cap_q=0 always.
